op_encoder: RTL and testbench

OP_ENCODER -- requirements
Module: op_encoder

---
 rtl/op_encoder_pkg.sv | 28 ++
 rtl/op_fifo.sv | 55 +++++
 rtl/op_encoder.sv | 85 ++++++++
 tb/tb_op_encoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/op_encoder_pkg.sv
// Shared types and constants for the opcode encoder.
// Holds the request kind enum, fixed opcodes and the no-jump code.
package op_encoder_pkg;

    localparam int OPW = 10;

    typedef enum logic [2:0] {
        KIND_NOP     = 3'd0,
        KIND_ALU     = 3'd1,
        KIND_ALU_ALT = 3'd2,
        KIND_LOAD    = 3'd3,
        KIND_STORE   = 3'd4,
        KIND_LI      = 3'd5,
        KIND_BRANCH  = 3'd6,
        KIND_CMP     = 3'd7
    } reqKind_e;

    localparam logic [OPW-1:0] OP_NOP   = 10'h000;
    localparam logic [OPW-1:0] OP_LOAD  = 10'h320;
    localparam logic [OPW-1:0] OP_STORE = 10'h340;
    localparam logic [OPW-1:0] OP_LI    = 10'h300;
    localparam logic [OPW-1:0] OP_CMP   = 10'h014;
    localparam logic [OPW-1:0] OP_ALT7  = 10'h010;
    localparam logic [OPW-1:0] OP_ALT3  = 10'h011;

    localparam logic [2:0] NO_JUMP = 3'd6;

endpackage

// File: rtl/op_fifo.sv
// Opcode FIFO: DEPTH entries (power of two), W bits wide.
// Ports: push/wrData in, pop in, rdData out (zero when empty), full, empty.
module op_fifo
    import op_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = OPW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wrData,
    input  logic         pop,
    output logic [W-1:0] rdData,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          pushEn;
    logic          popEn;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign pushEn = push && !full;
    assign popEn  = pop && !empty;
    assign rdData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (pushEn) mem[wrPtr] <= wrData;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + 1'b1;
            if (popEn)  rdPtr <= rdPtr + 1'b1;
            unique case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/op_encoder.sv
// Encodes instruction-class requests into 10-bit opcodes, queued in a FIFO.
// Ports: req_* request handshake, op_* opcode handshake, err pulse, err_cnt.
module op_encoder
    import op_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_kind,
    input  logic [3:0]      req_alu,
    input  logic [2:0]      req_cond,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [OPW-1:0]  op,
    output logic            err,
    output logic [ERRW-1:0] err_cnt
);

    logic [OPW-1:0] encOp;
    logic           illegal;
    logic           accept;
    logic           full;
    logic           empty;

    always_comb begin
        encOp   = OP_NOP;
        illegal = 1'b0;
        unique case (reqKind_e'(req_kind))
            KIND_NOP:   encOp = OP_NOP;
            KIND_ALU: begin
                encOp   = {6'b0, req_alu};
                illegal = (req_alu == 4'd0);
            end
            KIND_ALU_ALT: begin
                if (req_alu == 4'd7)      encOp = OP_ALT7;
                else if (req_alu == 4'd3) encOp = OP_ALT3;
                else                      illegal = 1'b1;
            end
            KIND_LOAD:  encOp = OP_LOAD;
            KIND_STORE: encOp = OP_STORE;
            KIND_LI:    encOp = OP_LI;
            KIND_BRANCH: begin
                encOp   = {2'b10, req_cond, 5'b0};
                illegal = (req_cond == NO_JUMP);
            end
            KIND_CMP:   encOp = OP_CMP;
            default:    encOp = OP_NOP;
        endcase
    end

    assign req_ready = !full;
    assign op_valid  = !empty;
    assign accept    = req_valid && req_ready;

    op_fifo #(
        .DEPTH (DEPTH),
        .W     (OPW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (accept && !illegal),
        .wrData (encOp),
        .pop    (op_ready),
        .rdData (op),
        .full   (full),
        .empty  (empty)
    );

    // Illegal requests are consumed, never queued; counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= accept && illegal;
            if (accept && illegal && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_op_encoder.sv
// Scoreboard bench for op_encoder: directed requests push expected opcodes,
// a monitor pops and compares on every opcode handshake.
module tb_op_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_kind;
    logic [3:0] req_alu;
    logic [2:0] req_cond;
    logic       op_valid;
    logic       op_ready;
    logic [9:0] op;
    logic       err;
    logic [7:0] err_cnt;

    int nChk = 0;
    int nPass = 0;
    int errExp = 0;
    int errSeen = 0;
    int errCntExp = 0;
    logic [9:0] expQ [$];
    logic [9:0] expHead;

    op_encoder #(.DEPTH(4), .ERRW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_alu   (req_alu),
        .req_cond  (req_cond),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nChk++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (op_valid && op_ready) begin
                if (expQ.size() == 0) begin
                    check("unexpected_op", {31'b0, op_valid}, 32'd0);
                end else begin
                    expHead = expQ.pop_front();
                    check("op_value", {22'b0, op}, {22'b0, expHead});
                end
            end else if (!op_valid) begin
                check("op_idle_zero", {22'b0, op}, 32'd0);
            end
            if (err) errSeen++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] k, input logic [3:0] a,
                        input logic [2:0] c, input bit legal,
                        input logic [9:0] e);
        bit ok;
        ok = 1'b0;
        req_kind  = k;
        req_alu   = a;
        req_cond  = c;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("ready_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        if (legal) expQ.push_back(e);
        else begin
            errExp++;
            if (errCntExp != 255) errCntExp++;
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !op_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", expQ.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_kind  = 3'd0;
        req_alu   = 4'd0;
        req_cond  = 3'd0;
        op_ready  = 1'b1;
        #3;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_valid", {31'b0, op_valid}, 32'd0);
        check("rst_op", {22'b0, op}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_errcnt", {24'b0, err_cnt}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LOAD/STORE/LI back to back, latency one.
        send(3'd3, 4'd0, 3'd0, 1'b1, 10'h320);
        check("lat_valid", {31'b0, op_valid}, 32'd1);
        check("lat_op", {22'b0, op}, 32'h320);
        send(3'd4, 4'd0, 3'd0, 1'b1, 10'h340);
        send(3'd5, 4'd0, 3'd0, 1'b1, 10'h300);
        waitDrain();
        check("no_err_legal", errSeen, 32'd0);

        // Fill while stalled, then drain.
        op_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            send(3'd1, 4'(i), 3'd0, 1'b1, 10'(i));
        req_kind  = 3'd1;
        req_alu   = 4'd0;
        req_valid = 1'b1;
        @(negedge clk);
        check("full_ready", {31'b0, req_ready}, 32'd0);
        check("hold_op1", {22'b0, op}, 32'h001);
        @(negedge clk);
        check("full_ready2", {31'b0, req_ready}, 32'd0);
        check("hold_op2", {22'b0, op}, 32'h001);
        check("hold_valid", {31'b0, op_valid}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("ignored_err", {31'b0, err}, 32'd0);
        check("ignored_cnt", {24'b0, err_cnt}, errCntExp);
        op_ready = 1'b1;
        waitDrain();
        check("ready_back", {31'b0, req_ready}, 32'd1);

        // Illegal requests.
        send(3'd1, 4'd0, 3'd0, 1'b0, 10'h0);
        send(3'd2, 4'd5, 3'd0, 1'b0, 10'h0);
        send(3'd6, 4'd0, 3'd6, 1'b0, 10'h0);
        waitDrain();
        check("err_pulses", errSeen, 32'd3);
        check("err_cnt3", {24'b0, err_cnt}, 32'd3);

        // Remaining encodings.
        send(3'd6, 4'd0, 3'd2, 1'b1, 10'h240);
        send(3'd7, 4'd0, 3'd0, 1'b1, 10'h014);
        send(3'd2, 4'd7, 3'd0, 1'b1, 10'h010);
        send(3'd2, 4'd3, 3'd0, 1'b1, 10'h011);
        send(3'd0, 4'd9, 3'd0, 1'b1, 10'h000);
        send(3'd1, 4'd15, 3'd0, 1'b1, 10'h00f);
        send(3'd6, 4'd0, 3'd7, 1'b1, 10'h2e0);
        waitDrain();

        // Reset mid-operation discards queued opcodes.
        op_ready = 1'b0;
        send(3'd1, 4'd6, 3'd0, 1'b1, 10'h006);
        send(3'd1, 4'd7, 3'd0, 1'b1, 10'h007);
        send(3'd1, 4'd8, 3'd0, 1'b1, 10'h008);
        @(negedge clk);
        #2 rst_n = 1'b0;
        expQ.delete();
        errCntExp = 0;
        #1;
        check("mid_rst_valid", {31'b0, op_valid}, 32'd0);
        check("mid_rst_op", {22'b0, op}, 32'd0);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        check("mid_rst_cnt", {24'b0, err_cnt}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        op_ready = 1'b1;
        send(3'd5, 4'd0, 3'd0, 1'b1, 10'h300);
        waitDrain();

        // Counter saturation.
        for (int i = 0; i < 254; i++)
            send(3'd1, 4'd0, 3'd0, 1'b0, 10'h0);
        check("cnt_254", {24'b0, err_cnt}, 32'd254);
        send(3'd2, 4'd1, 3'd0, 1'b0, 10'h0);
        check("cnt_255", {24'b0, err_cnt}, 32'd255);
        for (int i = 0; i < 45; i++)
            send(3'd6, 4'd0, 3'd6, 1'b0, 10'h0);
        check("cnt_sat", {24'b0, err_cnt}, 32'd255);
        check("cnt_model", {24'b0, err_cnt}, errCntExp);
        waitDrain();
        check("err_total", errSeen, errExp);
        check("q_empty", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
